delta_reconstruct: RTL and testbench

//   Inverse of the lane-wise absolute-difference stage. Takes a stream of per-lane

---
 rtl/delta_reconstruct.sv | 160 ++++++++++++++++
 tb/tb_delta_reconstruct.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delta_reconstruct.sv
// delta_reconstruct
//   Rebuilds NUM_LANES x WIDTH vectors from a stream of per-lane difference
//   magnitudes and sign bits. Each lane adds or subtracts its magnitude from
//   a running reference and saturates to 0..2^WIDTH-1. Beats are grouped into
//   frames of FRAME_BEATS accepted beats, the first marked by in_sof.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_sof                first beat of a frame
//   in_diff               per-lane magnitude, lane i = [i*WIDTH +: WIDTH]
//   in_sign               per lane: 1 = subtract, 0 = add
//   out_valid/out_ready   output handshake
//   out_vec               reconstructed vector (same lane packing)
//   out_sat               per lane: result was clamped
//   frame_done            one-cycle pulse after the last beat of a frame
//   frame_err             sticky framing error
//   err_clr               synchronous clear of frame_err
//   state_dbg             current FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. The producer holds its payload stable while valid is high and ready is
// low. in_ready = !out_valid | out_ready, so the single output register is the
// only storage and there is no combinational path from in_* to out_*.
module delta_reconstruct #(
  parameter int WIDTH       = 4,
  parameter int NUM_LANES   = 4,
  parameter int FRAME_BEATS = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sof,
  input  logic [NUM_LANES*WIDTH-1:0]   in_diff,
  input  logic [NUM_LANES-1:0]         in_sign,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_LANES*WIDTH-1:0]   out_vec,
  output logic [NUM_LANES-1:0]         out_sat,
  output logic                         frame_done,
  output logic                         frame_err,
  input  logic                         err_clr,
  output logic                         state_dbg
);

  localparam int CW = $clog2(FRAME_BEATS + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                       state, state_nxt;
  logic [CW-1:0]                count, count_nxt;
  logic                         accept;
  logic                         produce;
  logic                         set_err;
  logic                         done_nxt;
  logic [NUM_LANES*WIDTH-1:0]   vec_nxt;
  logic [NUM_LANES-1:0]         sat_nxt;
  logic [WIDTH:0]               lane_base, lane_diff, lane_sum;

  assign in_ready  = !out_valid | out_ready;
  assign accept    = in_valid & in_ready;
  assign state_dbg = (state == RUN);

  // Per-lane reconstruction. The output register doubles as the reference
  // vector: it is loaded exactly when a beat produces output, which is also
  // exactly when the reference must advance.
  always_comb begin
    vec_nxt   = '0;
    sat_nxt   = '0;
    lane_base = '0;
    lane_diff = '0;
    lane_sum  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_base = in_sof ? '0 : {1'b0, out_vec[i*WIDTH +: WIDTH]};
      lane_diff = {1'b0, in_diff[i*WIDTH +: WIDTH]};
      if (in_sign[i]) begin
        if (lane_diff > lane_base) begin
          vec_nxt[i*WIDTH +: WIDTH] = '0;
          sat_nxt[i]                = 1'b1;
        end else begin
          lane_sum                  = lane_base - lane_diff;
          vec_nxt[i*WIDTH +: WIDTH] = lane_sum[WIDTH-1:0];
        end
      end else begin
        lane_sum = lane_base + lane_diff;
        if (lane_sum[WIDTH]) begin
          vec_nxt[i*WIDTH +: WIDTH] = '1;
          sat_nxt[i]                = 1'b1;
        end else begin
          vec_nxt[i*WIDTH +: WIDTH] = lane_sum[WIDTH-1:0];
        end
      end
    end
  end

  // Frame FSM: IDLE waits for SOF; RUN counts beats until the frame completes.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    produce   = 1'b0;
    set_err   = 1'b0;
    done_nxt  = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (in_sof) begin
            produce   = 1'b1;
            count_nxt = CW'(1);
            state_nxt = RUN;
          end else begin
            // Orphan beat outside a frame: dropped.
            set_err = 1'b1;
          end
        end
        RUN: begin
          produce = 1'b1;
          if (in_sof) begin
            // Early SOF cuts the current frame and restarts counting.
            set_err   = 1'b1;
            count_nxt = CW'(1);
          end else if (count == CW'(FRAME_BEATS - 1)) begin
            done_nxt  = 1'b1;
            count_nxt = '0;
            state_nxt = IDLE;
          end else begin
            count_nxt = count + CW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      out_valid  <= 1'b0;
      out_vec    <= '0;
      out_sat    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      frame_done <= done_nxt;
      if (set_err)      frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (in_ready) begin
        out_valid <= produce;
        if (produce) begin
          out_vec <= vec_nxt;
          out_sat <= sat_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_delta_reconstruct.sv
module tb_delta_reconstruct;

  localparam int W    = 4;
  localparam int L    = 4;
  localparam int FB   = 16;
  localparam int MAXV = (1 << W) - 1;

  logic           clk, rst_n;
  logic           in_valid, in_ready, in_sof;
  logic [L*W-1:0] in_diff;
  logic [L-1:0]   in_sign;
  logic           out_valid, out_ready;
  logic [L*W-1:0] out_vec;
  logic [L-1:0]   out_sat;
  logic           frame_done, frame_err, err_clr, state_dbg;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  delta_reconstruct #(.WIDTH(W), .NUM_LANES(L), .FRAME_BEATS(FB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_diff(in_diff), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_sat(out_sat),
    .frame_done(frame_done), .frame_err(frame_err), .err_clr(err_clr),
    .state_dbg(state_dbg)
  );

  // ---------------- reference model + scoreboard ----------------
  logic [L+L*W-1:0] exp_q[$];
  int  m_ref[L];
  bit  m_in_frame;
  int  m_beats;
  bit  exp_done, exp_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < L; i++) m_ref[i] = 0;
      m_in_frame = 0;
      m_beats    = 0;
      exp_done   = 0;
      exp_err    = 0;
    end else begin
      logic [L+L*W-1:0] got, want;
      bit set_e, done_n;
      checks++;
      if (frame_done !== exp_done) begin
        errors++;
        $display("FAIL frame_done got %0b want %0b at %0t", frame_done, exp_done, $time);
      end
      checks++;
      if (frame_err !== exp_err) begin
        errors++;
        $display("FAIL frame_err got %0b want %0b at %0t", frame_err, exp_err, $time);
      end
      if (out_valid && out_ready) begin
        checks++;
        got = {out_sat, out_vec};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected got %h with nothing expected at %0t", got, $time);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL out_data got %h want %h at %0t", got, want, $time);
          end
        end
      end
      set_e  = 0;
      done_n = 0;
      if (in_valid && in_ready) begin
        if (!m_in_frame && !in_sof) begin
          set_e = 1;
        end else begin
          logic [L*W-1:0] v;
          logic [L-1:0]   s;
          v = '0;
          s = '0;
          for (int i = 0; i < L; i++) begin
            int b, d, r;
            b = in_sof ? 0 : m_ref[i];
            d = int'(in_diff[i*W +: W]);
            r = in_sign[i] ? b - d : b + d;
            if (r < 0)    begin r = 0;    s[i] = 1'b1; end
            if (r > MAXV) begin r = MAXV; s[i] = 1'b1; end
            m_ref[i] = r;
            v[i*W +: W] = W'(r);
          end
          exp_q.push_back({s, v});
          if (in_sof) begin
            if (m_in_frame) set_e = 1;
            m_in_frame = 1;
            m_beats    = 1;
          end else begin
            m_beats++;
            if (m_beats == FB) begin
              done_n     = 1;
              m_in_frame = 0;
              m_beats    = 0;
            end
          end
        end
      end
      exp_done = done_n;
      if (set_e)        exp_err = 1;
      else if (err_clr) exp_err = 0;
    end
  end

  // ---------------- random downstream ready ----------------
  bit rand_ready_en = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready_en) out_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_diff  = '0;
    in_sign  = '0;
    err_clr  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send(input logic sof, input logic [L*W-1:0] diff, input logic [L-1:0] sign);
    bit acc;
    int n;
    acc = 0;
    n   = 0;
    in_valid = 1'b1;
    in_sof   = sof;
    in_diff  = diff;
    in_sign  = sign;
    while (!acc && n < 200) begin
      @(negedge clk);
      if (in_ready) acc = 1;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready stayed 0 for %0d cycles", n);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    rand_ready_en = 0;
    #0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d outputs still pending want 0", exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({out_valid, out_vec, out_sat, frame_done, frame_err, in_ready} !== {1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got v=%0b vec=%h sat=%h done=%0b err=%0b rdy=%0b want 0,0,0,0,0,1",
               out_valid, out_vec, out_sat, frame_done, frame_err, in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ramp();
    do_reset();
    for (int k = 1; k <= FB; k++) begin
      int e;
      e = (3 * k > MAXV) ? MAXV : 3 * k;
      send(k == 1, 16'h0003, 4'h0);
      checks++;
      if (out_vec !== 16'(e) || out_sat !== {3'b000, 1'(3 * k > MAXV)} || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL ramp_beat%0d got vec=%h sat=%h want vec=%h sat=%0b", k, out_vec, out_sat, e, 3 * k > MAXV);
      end
      checks++;
      if (frame_done !== (k == FB)) begin
        errors++;
        $display("FAIL ramp_done beat%0d got %0b want %0b", k, frame_done, k == FB);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL ramp_done_pulse got %0b want 0", frame_done);
    end
    drain();
  endtask

  task automatic test_sub_sat();
    do_reset();
    send(1'b1, 16'h1111, 4'b1111);
    checks++;
    if (out_vec !== 16'h0000 || out_sat !== 4'b1111) begin
      errors++;
      $display("FAIL sub_sat got vec=%h sat=%b want 0000 1111", out_vec, out_sat);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [L*W-1:0] held;
    do_reset();
    out_ready = 1'b0;
    send(1'b1, 16'h4321, 4'h0);
    held = out_vec;
    fork
      send(1'b0, 16'h1111, 4'h0);
      begin
        repeat (5) begin
          @(negedge clk);
          checks++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_vec !== held) begin
            errors++;
            $display("FAIL backpressure got rdy=%0b v=%0b vec=%h want 0,1,%h", in_ready, out_valid, out_vec, held);
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    checks++;
    if (out_vec !== 16'h5432) begin
      errors++;
      $display("FAIL backpressure_release got %h want 5432", out_vec);
    end
    drain();
  endtask

  task automatic test_idle_err();
    do_reset();
    send(1'b0, 16'h7777, 4'h0);
    checks++;
    if (out_valid !== 1'b0 || frame_err !== 1'b1) begin
      errors++;
      $display("FAIL idle_orphan got v=%0b err=%0b want 0,1", out_valid, frame_err);
    end
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clr got %0b want 0", frame_err);
    end
    drain();
  endtask

  task automatic test_early_sof();
    logic [L*W-1:0] d;
    do_reset();
    send(1'b1, 16'($urandom), 4'h0);
    for (int k = 2; k <= 6; k++) send(1'b0, 16'($urandom), 4'($urandom));
    d = 16'($urandom);
    send(1'b1, d, 4'h0);
    checks++;
    if (out_vec !== d || out_sat !== 4'h0 || frame_err !== 1'b1) begin
      errors++;
      $display("FAIL early_sof got vec=%h sat=%h err=%0b want %h 0 1", out_vec, out_sat, frame_err, d);
    end
    for (int k = 2; k <= FB; k++) begin
      send(1'b0, 16'h0000, 4'h0);
      checks++;
      if (frame_done !== (k == FB)) begin
        errors++;
        $display("FAIL early_sof_done beat%0d got %0b want %0b", k, frame_done, k == FB);
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(1'b1, 16'h2222, 4'h0);
    send(1'b0, 16'h1111, 4'h0);
    send(1'b0, 16'h1111, 4'h0);
    out_ready = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre got v=%0b want 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_vec, out_sat, frame_done, frame_err} !== 23'h0) begin
      errors++;
      $display("FAIL reset_mid got v=%0b vec=%h sat=%h done=%0b err=%0b want all 0",
               out_valid, out_vec, out_sat, frame_done, frame_err);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 1; k <= FB; k++) send(k == 1, 16'($urandom), 4'($urandom));
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_frame got done=%0b want 1", frame_done);
    end
    drain();
  endtask

  task automatic test_random();
    do_reset();
    rand_ready_en = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      err_clr = ($urandom_range(0, 9) == 0);
      send((i == 0) || ($urandom_range(0, 19) == 0), 16'($urandom), 4'($urandom));
    end
    err_clr = 1'b0;
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_diff = '0;
    in_sign = '0;
    err_clr = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_ramp();
    test_sub_sat();
    test_backpressure();
    test_idle_err();
    test_early_sof();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
